// File: rtl/inc_pkg.sv
// Shared defaults and FSM state encoding for the sequential incrementer.
package inc_pkg;
  localparam int INC_WIDTH = 20;
  localparam int INC_CHUNK = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/inc_slice.sv
// CHUNK-bit half-adder chain: sum = in + cin, cout = carry out of the top bit.
module inc_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] in,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ha
      assign sum[gi]          = in[gi] ^ w_carry[gi];
      assign w_carry[gi + 1]  = in[gi] & w_carry[gi];
    end
  endgenerate

  assign cout = w_carry[CHUNK];
endmodule

// File: rtl/inc_seq.sv
// Multi-cycle incrementer: out = a + 1, one CHUNK-bit slice per clock, LSB first.
// Optional macro INC_EARLY_EXIT_EN finishes as soon as a slice produces no carry.
module inc_seq
  import inc_pkg::*;
#(
  parameter int WIDTH = INC_WIDTH,
  parameter int CHUNK = INC_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  logic [CHUNK-1:0] w_slice_in;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_work_upd;
  logic             w_last;
  logic             w_exit;

  assign w_slice_in = r_work[r_idx * CHUNK +: CHUNK];

  inc_slice #(.CHUNK(CHUNK)) u_slice (
    .in   (w_slice_in),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_comb begin
    w_work_upd = r_work;
    w_work_upd[r_idx * CHUNK +: CHUNK] = w_slice_sum;
  end

  assign w_last = (r_idx == LAST_IDX);

`ifdef INC_EARLY_EXIT_EN
  // Once the carry dies, the remaining upper slices already hold their final value.
  assign w_exit = w_last | ~w_slice_cout;
`else
  assign w_exit = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_out   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= a;
            r_carry <= 1'b1;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work  <= w_work_upd;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_exit) begin
            // Results are registered on entry so they are valid during the done cycle.
            r_out   <= w_work_upd;
            r_cout  <= w_slice_cout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done = (r_state == ST_DONE);
  assign out  = r_out;
  assign cout = r_cout;
endmodule

// File: tb/tb_inc_seq.sv
// Directed self-checking bench for inc_seq; honours INC_EARLY_EXIT_EN for expected latencies.
`timescale 1ns/1ps
module tb_inc_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] a;
  logic        busy;
  logic        done;
  logic [19:0] out;
  logic        cout;

  int errors = 0;
  int checks = 0;

`ifdef INC_EARLY_EXIT_EN
  localparam int LAT_00001 = 2;
  localparam int LAT_00000 = 2;
  localparam int LAT_FFC00 = 2;
  localparam int LAT_FFFFF = 6;
  localparam int LAT_0000F = 3;
  localparam int LAT_000FF = 4;
`else
  localparam int LAT_00001 = 6;
  localparam int LAT_00000 = 6;
  localparam int LAT_FFC00 = 6;
  localparam int LAT_FFFFF = 6;
  localparam int LAT_0000F = 6;
  localparam int LAT_000FF = 6;
`endif

  inc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and observe 10 cycles; cycle 1 is the one after the accepting edge.
  // A second start with rep_a is driven in cycle rep_cyc (0 = none).
  task automatic run_op(input logic [19:0] av, input int rep_cyc, input logic [19:0] rep_a,
                        output int dcyc, output logic [19:0] o, output logic c,
                        output int ndone, output int busy_bad, output int stale_bad);
    logic [19:0] prev_out;
    prev_out  = out;
    dcyc      = -1;
    o         = 'x;
    c         = 1'bx;
    ndone     = 0;
    busy_bad  = 0;
    stale_bad = 0;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == rep_cyc);
      a     = (cyc == rep_cyc) ? rep_a : ~av;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = cyc;
          o    = out;
          c    = cout;
        end
      end
      if (dcyc < 0 && out !== prev_out) stale_bad++;
      if ((dcyc < 0 || cyc <= dcyc) ? (busy !== 1'b1) : (busy !== 1'b0)) busy_bad++;
    end
    start = 1'b0;
    $display("op a=%05h -> done_cycle=%0d out=%05h cout=%0b dones=%0d", av, dcyc, o, c, ndone);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 20'hABCDE;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, out, cout} !== 23'd0) begin
      errors++;
      $display("FAIL reset_in: busy=%0b done=%0b out=%05h cout=%0b, want all 0", busy, done, out, cout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, out, cout} !== 23'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b done=%0b out=%05h cout=%0b, want all 0 with start low", busy, done, out, cout);
    end
  endtask

  // Shared check sequence kept inline per scenario: latency, result, carry, single pulse, busy.
  task automatic test_basic();
    int dc, nd, bb, sb;
    logic [19:0] o;
    logic c;
    run_op(20'h00001, 0, 20'h0, dc, o, c, nd, bb, sb);
    checks++; if (dc !== LAT_00001) begin errors++; $display("FAIL basic_lat: got %0d want %0d", dc, LAT_00001); end
    checks++; if (o !== 20'h00002) begin errors++; $display("FAIL basic_out: got %05h want 00002", o); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %0b want 0", c); end
    checks++; if (nd !== 1 || bb !== 0 || sb !== 0) begin errors++; $display("FAIL basic_hs: dones=%0d busy_bad=%0d stale_bad=%0d want 1/0/0", nd, bb, sb); end
  endtask

  task automatic test_patterns();
    int dc, nd, bb, sb;
    logic [19:0] o;
    logic c;
    run_op(20'h00000, 0, 20'h0, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'h00001 || c !== 1'b0) begin errors++; $display("FAIL zero_res: got %05h/%0b want 00001/0", o, c); end
    checks++; if (dc !== LAT_00000) begin errors++; $display("FAIL zero_lat: got %0d want %0d", dc, LAT_00000); end
    run_op(20'hFFC00, 0, 20'h0, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'hFFC01 || c !== 1'b0) begin errors++; $display("FAIL ffc00_res: got %05h/%0b want FFC01/0", o, c); end
    checks++; if (dc !== LAT_FFC00 || nd !== 1 || bb !== 0 || sb !== 0) begin errors++; $display("FAIL ffc00_hs: lat=%0d dones=%0d busy_bad=%0d stale_bad=%0d want %0d/1/0/0", dc, nd, bb, sb, LAT_FFC00); end
  endtask

  task automatic test_wrap();
    int dc, nd, bb, sb;
    logic [19:0] o;
    logic c;
    run_op(20'hFFFFF, 0, 20'h0, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'h00000) begin errors++; $display("FAIL wrap_out: got %05h want 00000", o); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %0b want 1", c); end
    checks++; if (dc !== LAT_FFFFF || nd !== 1 || bb !== 0 || sb !== 0) begin errors++; $display("FAIL wrap_hs: lat=%0d dones=%0d busy_bad=%0d stale_bad=%0d want %0d/1/0/0", dc, nd, bb, sb, LAT_FFFFF); end
  endtask

  task automatic test_back_to_back();
    int dc, nd, bb, sb;
    logic [19:0] o;
    logic c;
    // Restart during RUN must be ignored.
    run_op(20'h0000F, 2, 20'h12345, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'h00010 || c !== 1'b0) begin errors++; $display("FAIL rerun_res: got %05h/%0b want 00010/0", o, c); end
    checks++; if (dc !== LAT_0000F || nd !== 1 || bb !== 0 || sb !== 0) begin errors++; $display("FAIL rerun_hs: lat=%0d dones=%0d busy_bad=%0d stale_bad=%0d want %0d/1/0/0", dc, nd, bb, sb, LAT_0000F); end
    // Start held only during the DONE cycle must not launch a new op.
    run_op(20'h0000F, LAT_0000F, 20'h12345, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'h00010 || dc !== LAT_0000F) begin errors++; $display("FAIL donestart_res: got %05h lat=%0d want 00010 lat=%0d", o, dc, LAT_0000F); end
    checks++; if (nd !== 1 || bb !== 0) begin errors++; $display("FAIL donestart_hs: dones=%0d busy_bad=%0d want 1/0", nd, bb); end
    checks++; if (out !== 20'h00010) begin errors++; $display("FAIL donestart_hold: out=%05h want 00010", out); end
  endtask

  task automatic test_reset_mid_run();
    int dc, nd, bb, sb, seen;
    logic [19:0] o;
    logic c;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 20'h000FF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, out, cout} !== 23'd0) begin
      errors++;
      $display("FAIL midrst: busy=%0b done=%0b out=%05h cout=%0b want all 0", busy, done, out, cout);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_nodone: busy/done seen %0d cycles want 0", seen); end
    $display("op a=000ff aborted by reset");
    run_op(20'h000FF, 0, 20'h0, dc, o, c, nd, bb, sb);
    checks++; if (o !== 20'h00100 || c !== 1'b0) begin errors++; $display("FAIL postrst_res: got %05h/%0b want 00100/0", o, c); end
    checks++; if (dc !== LAT_000FF || nd !== 1 || bb !== 0) begin errors++; $display("FAIL postrst_hs: lat=%0d dones=%0d busy_bad=%0d want %0d/1/0", dc, nd, bb, LAT_000FF); end
  endtask

  initial begin
    start = 1'b0;
    a     = '0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
